dsm_nch: RTL and testbench
==========================

Name: dsm_nch

Overview:
Multi-channel 1-bit delta-sigma modulator for PWM/PDM audio and DAC drive. It is the parametrised successor to the single-channel first-order DSM and adds the following:
- CH parallel channels
- a run-time selectable first- or second-order noise-shaping loop
- an internal update-rate prescaler
- a shared valid/ready sample-write port with per-channel double buffering

It sits between the sample/voice generator and the differential output pins.

Parameters:
CH, 4, number of independent modulator channels (>=1)
DEPTH, 8, unsigned input sample width in bits (>=2)
DIV, 1, prescaler ratio: one modulator update every DIV clocks (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  run control; low = idle/mute
order_sel  input  1  0 = first order, 1 = second order; captured only while enable=0
in_valid  input  1  sample write request
in_ch  input  $clog2(CH) (min 1)  target channel of the write
in_data  input  DEPTH  unsigned sample
in_ready  output  1  write can be accepted for in_ch
dsm_out_p  output  CH  modulator bit per channel
dsm_out_n  output  CH  complement drive per channel

Behaviour:
- Reset (async, reset_n=0):
  - dsm_out_p=0 and dsm_out_n=0 for all channels.
  - All error states, shadow, active and pend registers, and the prescaler clear to 0.
  - order register = 0.
  - in_ready is combinational and therefore reads 1.
- Prescaler:
  - cnt width is $clog2(DIV), min 1.
  - While enable=1, cnt increments and wraps at DIV-1.
  - tick = enable && cnt==DIV-1. With DIV=1, tick is 1 every enabled cycle.
  - While enable=0, cnt is held at 0.
- Write port:
  - in_ready = ~pend[in_ch].
  - A write is accepted when in_valid && in_ready: shadow[in_ch] <= in_data and pend[in_ch] <= 1.
  - Writes are accepted regardless of enable.
  - in_ch >= CH: in_ready=1 and the write is silently dropped.
- Update on a tick edge, all channels in parallel:
  - x = pend ? shadow : active; active <= x; pend <= 0.
  - A sample written before a tick is therefore used at that tick, with no extra latency.
  - A write accepted on the same edge as the tick (pend was 0) is used at the next tick.
- Quantiser (both orders):
  - v is signed, DEPTH+4 bits.
  - y = (v >= 2^(DEPTH-1)).
  - e = v - y*2^DEPTH.
  - dsm_out_p <= y and dsm_out_n <= ~y, both registered; outputs change on the tick edge.
- Order 1: v = x + e1; then e1 <= e.
- Order 2:
  - v = x + 2*e1 - e2; then e2 <= e1 and e1 <= e.
  - e is saturated to the signed DEPTH+1-bit range [-2^DEPTH, 2^DEPTH-1], so overload never wraps.
- Mean of y over time equals x/2^DEPTH for in-range input.
- Between ticks the outputs and all state hold.
- enable=0:
  - outputs go to 0/0 on the next edge and e1/e2 clear.
  - active, shadow and pend are retained.
  - order register <= order_sel.
- enable rising: the first tick occurs DIV clocks later, starting from zero error state.
- Reset asserted mid-run: immediate async clear as above; no partial update completes.

Decomposition:
- Package dsm_pkg: order_e enum (ORDER1=1'b0, ORDER2=1'b1), and function err_sat(v, depth) for the saturation rule.
- Sub-module dsm_core: one channel's quantiser, error registers and output flops.
  - Inputs: x, tick, clear, order.
  - Instantiated CH times in a generate loop.
  - The top level holds the prescaler, write port and shadow/active buffering.

Test Plan:
1. Reset: run both orders, pulse reset_n low mid-stream → same cycle all dsm_out_p/n=0, in_ready=1; after release with enable=1, the first output bit is consistent with zero error state.
2. Order1, DIV=1, DEPTH=8: ch0 x=0x80 → p=1,0,1,0…; x=0x40 → p=0,1,0,0 repeating; x=0x00 → p=0 constant; n=~p throughout while enabled.
3. Order2, x=0x80 → p=1,0,0,1 repeating; order_sel toggled while enable=1 → ignored until enable drops.
4. DIV=4: x=0x80 order1 → each output bit held exactly 4 clocks; first change 4 clocks after enable rises.
5. Handshake:
   - write ch2 then write ch2 again before a tick → second write sees in_ready=0; a ch1 write in the same cycle window is accepted.
   - At the tick, ch2 uses the first value and in_ready returns to 1.
   - A write on the tick edge is used at the following tick.
6. Order2 overload: x=0xFF for 1024 ticks → no X; e1/e2 stay within [-256,255]; ones count ≥ 990. Then enable=0 → outputs 0/0 next clock.

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared types and helpers for the multi-channel delta-sigma modulator.
// Loop order selection and the error saturation rule used by the second-order loop.
package dsm_pkg;

    typedef enum logic {
        ORDER1 = 1'b0,
        ORDER2 = 1'b1
    } order_e;

    // Clamp v to the signed (depth+1)-bit range [-2^depth, 2^depth-1].
    function automatic int err_sat(int v, int unsigned depth);
        int hi;
        int lo;
        hi = (1 << depth) - 1;
        lo = -(1 << depth);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/dsm_core.sv
// One modulator channel: quantiser, first/second-order error feedback and output flops.
// State advances only on tick; clear forces outputs low and zeroes the error history.
module dsm_core
    import dsm_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DEPTH-1:0] x,
    input  logic             tick,
    input  logic             clear,
    input  order_e           order,
    output logic             out_p,
    output logic             out_n
);

    localparam int unsigned VW = DEPTH + 4;
    localparam int unsigned EW = DEPTH + 1;
    localparam logic signed [VW-1:0] HALF = VW'(1) <<< (DEPTH - 1);
    localparam logic signed [VW-1:0] FULL = VW'(1) <<< DEPTH;

    logic signed [EW-1:0] e1_q, e1_d;
    logic signed [EW-1:0] e2_q, e2_d;
    logic                 p_q, p_d;
    logic                 n_q, n_d;
    logic signed [VW-1:0] v;
    logic signed [VW-1:0] e_raw;
    logic                 y;

    always_comb begin
        if (order == ORDER2) begin
            v = $signed({{4{1'b0}}, x}) + (VW'(e1_q) <<< 1) - VW'(e2_q);
        end else begin
            v = $signed({{4{1'b0}}, x}) + VW'(e1_q);
        end
        y     = (v >= HALF);
        e_raw = y ? (v - FULL) : v;
    end

    always_comb begin
        e1_d = e1_q;
        e2_d = e2_q;
        p_d  = p_q;
        n_d  = n_q;
        if (clear) begin
            e1_d = '0;
            e2_d = '0;
            p_d  = 1'b0;
            n_d  = 1'b0;
        end else if (tick) begin
            p_d = y;
            n_d = ~y;
            if (order == ORDER2) begin
                // Saturate so a full-scale input cannot wrap the error history.
                e2_d = e1_q;
                e1_d = EW'(err_sat(int'(e_raw), DEPTH));
            end else begin
                e1_d = EW'(e_raw);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e1_q <= '0;
            e2_q <= '0;
            p_q  <= 1'b0;
            n_q  <= 1'b0;
        end else begin
            e1_q <= e1_d;
            e2_q <= e2_d;
            p_q  <= p_d;
            n_q  <= n_d;
        end
    end

    assign out_p = p_q;
    assign out_n = n_q;

endmodule

// File: rtl/dsm_nch.sv
// Multi-channel 1-bit delta-sigma modulator with update prescaler and a shared
// valid/ready write port feeding per-channel shadow/active sample buffers.
module dsm_nch
    import dsm_pkg::*;
#(
    parameter int unsigned CH    = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  enable,
    input  logic                                  order_sel,
    input  logic                                  in_valid,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] in_ch,
    input  logic [DEPTH-1:0]                      in_data,
    output logic                                  in_ready,
    output logic [CH-1:0]                         dsm_out_p,
    output logic [CH-1:0]                         dsm_out_n
);

    localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        tick;
    order_e                      order_q, order_d;
    logic [CH-1:0][DEPTH-1:0]    shadow_q, shadow_d;
    logic [CH-1:0][DEPTH-1:0]    active_q, active_d;
    logic [CH-1:0]               pend_q, pend_d;
    logic [CH-1:0][DEPTH-1:0]    x;

    always_comb begin
        if (!enable || cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        tick    = enable && (cnt_q == CNT_MAX);
        order_d = enable ? order_q : order_e'(order_sel);
    end

    // Out-of-range channels report ready and their writes fall through unmatched.
    always_comb begin
        in_ready = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (in_ch == CHW'(i)) begin
                in_ready = ~pend_q[i];
            end
        end
    end

    // Tick consumes pending samples first, so a same-edge write re-arms pend.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        for (int i = 0; i < CH; i++) begin
            x[i] = pend_q[i] ? shadow_q[i] : active_q[i];
            if (tick) begin
                active_d[i] = x[i];
                pend_d[i]   = 1'b0;
            end
            if (in_valid && in_ch == CHW'(i) && !pend_q[i]) begin
                shadow_d[i] = in_data;
                pend_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            order_q  <= ORDER1;
            shadow_q <= '0;
            active_q <= '0;
            pend_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            order_q  <= order_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        dsm_core #(
            .DEPTH (DEPTH)
        ) u_core (
            .clk     (clk),
            .reset_n (reset_n),
            .x       (x[g]),
            .tick    (tick),
            .clear   (~enable),
            .order   (order_q),
            .out_p   (dsm_out_p[g]),
            .out_n   (dsm_out_n[g])
        );
    end

endmodule

// File: tb/tb_dsm_nch.sv
// Bench for dsm_nch: behavioural scoreboard on a DIV=1 instance plus fixed
// pattern checks on both a DIV=1 and a DIV=4 instance.
module tb_dsm_nch;

    localparam int CH = 4;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic enable, order_sel, in_valid;
    logic [1:0] in_ch;
    logic [7:0] in_data;
    logic in_ready;
    logic [CH-1:0] p, n;

    logic en4, osel4, v4;
    logic [1:0] ch4;
    logic [7:0] d4;
    logic r4;
    logic [2:0] p4, n4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsm_nch #(.CH(CH), .DEPTH(D), .DIV(1)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .order_sel (order_sel),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .dsm_out_p (p),
        .dsm_out_n (n)
    );

    dsm_nch #(.CH(3), .DEPTH(D), .DIV(4)) u_dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (en4),
        .order_sel (osel4),
        .in_valid  (v4),
        .in_ch     (ch4),
        .in_data   (d4),
        .in_ready  (r4),
        .dsm_out_p (p4),
        .dsm_out_n (n4)
    );

    // Reference model state for u_dut.
    int  m_e1[CH], m_e2[CH], m_act[CH], m_sh[CH];
    bit  m_pend[CH];
    bit  m_order;
    logic [CH-1:0] m_p, m_n;
    logic [2*CH-1:0] exp_q[$];

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_e1[i] = 0; m_e2[i] = 0; m_act[i] = 0; m_sh[i] = 0; m_pend[i] = 0;
        end
        m_order = 0;
        m_p = '0;
        m_n = '0;
        exp_q.delete();
    endtask

    // One clock edge of the reference model; DIV=1 so every enabled edge ticks.
    task automatic model_edge();
        bit rdy;
        int xv, v, e, y;
        rdy = !m_pend[in_ch];
        for (int i = 0; i < CH; i++) begin
            if (!enable) begin
                m_e1[i] = 0; m_e2[i] = 0; m_p[i] = 0; m_n[i] = 0;
            end else begin
                xv = m_pend[i] ? m_sh[i] : m_act[i];
                m_act[i] = xv;
                m_pend[i] = 0;
                v = m_order ? xv + 2 * m_e1[i] - m_e2[i] : xv + m_e1[i];
                y = (v >= 128) ? 1 : 0;
                e = v - y * 256;
                if (m_order) begin
                    if (e > 255) e = 255;
                    if (e < -256) e = -256;
                    m_e2[i] = m_e1[i];
                end
                m_e1[i] = e;
                m_p[i] = y[0];
                m_n[i] = !y[0];
            end
        end
        if (in_valid && rdy) begin
            m_sh[in_ch] = in_data;
            m_pend[in_ch] = 1;
        end
        if (!enable) m_order = order_sel;
        exp_q.push_back({m_p, m_n});
    endtask

    task automatic step();
        logic [2*CH-1:0] exp;
        #1;
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, !m_pend[in_ch]});
        model_edge();
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check_eq("dsm_out", {24'd0, p, n}, {24'd0, exp});
    endtask

    // Load data into ch while idle, then run len ticks comparing p[ch] to pat.
    task automatic run_pattern(string tag, int ch, logic [7:0] data, logic ord,
                               logic [15:0] pat, int len);
        enable = 0; order_sel = ord;
        in_valid = 1; in_ch = 2'(ch); in_data = data;
        step();
        in_valid = 0;
        enable = 1;
        for (int k = 0; k < len; k++) begin
            step();
            check_eq(tag, {31'd0, p[ch]}, {31'd0, pat[k]});
            check_eq("n_compl", {31'd0, n[ch]}, {31'd0, ~pat[k]});
        end
    endtask

    initial begin
        int ones;
        bit xbad;
        logic [15:0] pat;
        reset_n = 0; enable = 0; order_sel = 0; in_valid = 0; in_ch = 0; in_data = 0;
        en4 = 0; osel4 = 0; v4 = 0; ch4 = 0; d4 = 0;
        model_reset();
        #2;
        check_eq("rst_p", {28'd0, p}, 32'd0);
        check_eq("rst_n", {28'd0, n}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;

        pat = 16'h5555; run_pattern("o1_x80", 0, 8'h80, 1'b0, pat, 8);
        pat = 16'h2222; run_pattern("o1_x40", 0, 8'h40, 1'b0, pat, 8);
        pat = 16'h0000; run_pattern("o1_x00", 0, 8'h00, 1'b0, pat, 8);
        pat = 16'h9999; run_pattern("o2_x80", 0, 8'h80, 1'b1, pat, 8);

        // order_sel changes while enabled must not take effect
        order_sel = 0;
        repeat (8) step();
        pat = 16'h5555; run_pattern("o1_again", 1, 8'h80, 1'b0, pat, 4);

        // Handshake: double write to ch2 while idle, ch1 write still accepted
        enable = 0; order_sel = 0;
        in_valid = 1; in_ch = 2; in_data = 8'h80; step();
        in_ch = 2; in_data = 8'h40; step();
        in_ch = 1; in_data = 8'h40; step();
        in_valid = 0; in_ch = 2;
        enable = 1;
        step();
        check_eq("hs_ch2_first", {31'd0, p[2]}, 32'd1);
        check_eq("hs_ch1", {31'd0, p[1]}, 32'd0);
        #1;
        check_eq("hs_ready_back", {31'd0, in_ready}, 32'd1);
        in_valid = 1; in_ch = 3; in_data = 8'h80; step();
        check_eq("hs_tick_wr_old", {31'd0, p[3]}, 32'd0);
        in_valid = 0; step();
        check_eq("hs_tick_wr_new", {31'd0, p[3]}, 32'd1);
        repeat (4) step();

        // Mid-run async reset with a pending write outstanding
        in_valid = 1; in_ch = 1; in_data = 8'h40; step();
        in_valid = 0;
        reset_n = 0;
        #1;
        check_eq("mid_rst_p", {28'd0, p}, 32'd0);
        check_eq("mid_rst_n", {28'd0, n}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        step();
        check_eq("post_rst_p", {28'd0, p}, 32'd0);
        check_eq("post_rst_n", {28'd0, n}, 32'hF);
        repeat (3) step();

        // Second-order overload
        enable = 0; order_sel = 1;
        in_valid = 1; in_ch = 0; in_data = 8'hFF; step();
        in_valid = 0; enable = 1;
        ones = 0; xbad = 0;
        for (int k = 0; k < 1024; k++) begin
            step();
            if ($isunknown({p, n})) xbad = 1;
            if (p[0] === 1'b1) ones++;
        end
        check_eq("ovl_no_x", {31'd0, xbad}, 32'd0);
        check_eq("ovl_ones_ge_990", {31'd0, (ones >= 990)}, 32'd1);
        enable = 0;
        step();
        check_eq("ovl_off_p", {28'd0, p}, 32'd0);
        check_eq("ovl_off_n", {28'd0, n}, 32'd0);

        // DIV=4 instance: hold time, first-tick latency, out-of-range write
        osel4 = 0; v4 = 1; ch4 = 0; d4 = 8'h80;
        @(posedge clk); #1;
        v4 = 1; ch4 = 3; d4 = 8'hFF;
        #1;
        check_eq("d4_oor_ready", {31'd0, r4}, 32'd1);
        @(posedge clk); #1;
        v4 = 0;
        en4 = 1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check_eq("d4_p0", {31'd0, p4[0]},
                     (k < 4) ? 32'd0 : {31'd0, ((k / 4) % 2 == 1)});
            check_eq("d4_n0", {31'd0, n4[0]},
                     (k < 4) ? 32'd0 : {31'd0, ((k / 4) % 2 == 0)});
        end
        check_eq("d4_oor_drop", {30'd0, p4[2:1]}, 32'd0);
        en4 = 0;
        @(posedge clk); #1;
        check_eq("d4_off", {26'd0, p4, n4}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
